vending_machine_change: RTL

Parametrised successor to the single-price Moore vending FSM. Accumulates nickel/dime/quarter credit and vends when credit reaches PRICE. Returns change or a cancel refund as dimes and nickels through a per-coin acknowledge handshake. Rejects illegal or overflowing coins. Sits between the coin-acceptor front end and the product/change dispensers.

---
 rtl/vending_pkg.sv | 37 +++
 rtl/vending_coin_decode.sv | 35 +++
 rtl/vending_machine_change.sv | 133 +++++++++++++
 3 files changed

// File: rtl/vending_pkg.sv
// ============================================================================
// Module   : vending_pkg
// Purpose  : Shared state encoding, coin values and parameter legality helpers
//            for the vending_machine_change block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vending_pkg;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_e;

  localparam int COIN_W = 5;

  localparam logic [COIN_W-1:0] NICKEL  = 5'd5;
  localparam logic [COIN_W-1:0] DIME    = 5'd10;
  localparam logic [COIN_W-1:0] QUARTER = 5'd25;

  function automatic bit is_mult5(input int v);
    return (v % 5) == 0;
  endfunction

  function automatic bit price_legal(input int price, input int max_credit);
    return is_mult5(price) && (price >= 5) && (price <= max_credit);
  endfunction

  function automatic bit max_credit_legal(input int max_credit, input int credit_w);
    return is_mult5(max_credit) && (max_credit > 0) && (max_credit < (1 << credit_w));
  endfunction

endpackage

`default_nettype wire

// File: rtl/vending_coin_decode.sv
// ============================================================================
// Module   : vending_coin_decode
// Purpose  : Combinational coin classifier: value/valid for a single coin,
//            illegal when more than one coin input is high.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vending_coin_decode
  import vending_pkg::*;
(
  input  logic              i_five,
  input  logic              i_ten,
  input  logic              i_quarter,
  output logic [COIN_W-1:0] o_value,
  output logic              o_valid,
  output logic              o_illegal
);

  always_comb begin
    o_value   = '0;
    o_valid   = 1'b0;
    o_illegal = 1'b0;
    case ({i_quarter, i_ten, i_five})
      3'b000: ;
      3'b001: begin o_value = NICKEL;  o_valid = 1'b1; end
      3'b010: begin o_value = DIME;    o_valid = 1'b1; end
      3'b100: begin o_value = QUARTER; o_valid = 1'b1; end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/vending_machine_change.sv
// ============================================================================
// Module   : vending_machine_change
// Purpose  : Parametrised vending FSM with credit accumulation, coin rejection
//            and dime/nickel change return over an acknowledge handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vending_machine_change
  import vending_pkg::*;
#(
  parameter int CREDIT_W   = 8,
  parameter int PRICE      = 30,
  parameter int MAX_CREDIT = 100
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                fiveCents,
  input  logic                tenCents,
  input  logic                twentyFiveCents,
  input  logic                cancel,
  input  logic                changeAck,
  output logic                theProduct,
  output logic                changeDime,
  output logic                changeNickel,
  output logic                coinReject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  if (!max_credit_legal(MAX_CREDIT, CREDIT_W)) begin : g_bad_max_credit
    $error("MAX_CREDIT must be a multiple of 5 and below 2**CREDIT_W");
  end
  if (!price_legal(PRICE, MAX_CREDIT)) begin : g_bad_price
    $error("PRICE must be a multiple of 5 within 5..MAX_CREDIT");
  end

  localparam int SUM_W = CREDIT_W + 1;
  localparam logic [SUM_W-1:0]    C_PRICE_S = SUM_W'(PRICE);
  localparam logic [SUM_W-1:0]    C_MAX_S   = SUM_W'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] C_DIME_C  = CREDIT_W'(DIME);
  localparam logic [CREDIT_W-1:0] C_NICK_C  = CREDIT_W'(NICKEL);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                coin_reject_q, coin_reject_d;

  logic [COIN_W-1:0]   w_coin_value;
  logic                w_coin_valid;
  logic                w_coin_illegal;
  logic                w_coin_any;
  logic [SUM_W-1:0]    w_sum;
  logic [CREDIT_W-1:0] w_change_amt;
  logic [CREDIT_W-1:0] w_after_ack;

  vending_coin_decode u_coin_decode (
    .i_five    (fiveCents),
    .i_ten     (tenCents),
    .i_quarter (twentyFiveCents),
    .o_value   (w_coin_value),
    .o_valid   (w_coin_valid),
    .o_illegal (w_coin_illegal)
  );

  assign w_coin_any   = w_coin_valid | w_coin_illegal;
  // One extra bit so an overflowing coin is caught before it wraps.
  assign w_sum        = {1'b0, credit_q} + SUM_W'(w_coin_value);
  assign w_change_amt = (credit_q >= C_DIME_C) ? C_DIME_C : C_NICK_C;
  assign w_after_ack  = credit_q - w_change_amt;

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    coin_reject_d = 1'b0;
    unique case (state_q)
      ACCEPT: begin
        if (cancel) begin
          coin_reject_d = w_coin_any;
          if (credit_q != '0) state_d = CHANGE;
        end else if (w_coin_illegal) begin
          coin_reject_d = 1'b1;
        end else if (w_coin_valid) begin
          if (w_sum > C_MAX_S) begin
            coin_reject_d = 1'b1;
          end else if (w_sum >= C_PRICE_S) begin
            credit_d = CREDIT_W'(w_sum - C_PRICE_S);
            state_d  = VEND;
          end else begin
            credit_d = CREDIT_W'(w_sum);
          end
        end
      end
      VEND: begin
        coin_reject_d = w_coin_any;
        state_d       = (credit_q == '0) ? ACCEPT : CHANGE;
      end
      CHANGE: begin
        coin_reject_d = w_coin_any;
        if (changeAck) begin
          credit_d = w_after_ack;
          if (w_after_ack == '0) state_d = ACCEPT;
        end
      end
      default: begin
        state_d  = ACCEPT;
        credit_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ACCEPT;
      credit_q      <= '0;
      coin_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      coin_reject_q <= coin_reject_d;
    end
  end

  // Outputs come straight from registers so no input reaches them combinationally.
  assign theProduct   = (state_q == VEND);
  assign changeDime   = (state_q == CHANGE) && (credit_q >= C_DIME_C);
  assign changeNickel = (state_q == CHANGE) && (credit_q == C_NICK_C);
  assign coinReject   = coin_reject_q;
  assign credit       = credit_q;
  assign busy         = (state_q != ACCEPT);

endmodule

`default_nettype wire
